// File: rtl/uart_frame_rx64_if.sv
// Receiver-side bundle for the 64-bit word link: serial line in, word and status pulses out.
// master is the receiver, slave is the line driver / word consumer.
interface uart_frame_rx64_if;
    logic        I_rxb;
    logic [63:0] O_data;
    logic        O_data_valid;
    logic        O_frame_err;
    logic        O_parity_err;
    logic        O_timeout;
    logic        O_busy;

    modport master (
        input  I_rxb,
        output O_data,
        output O_data_valid,
        output O_frame_err,
        output O_parity_err,
        output O_timeout,
        output O_busy
    );

    modport slave (
        output I_rxb,
        input  O_data,
        input  O_data_valid,
        input  O_frame_err,
        input  O_parity_err,
        input  O_timeout,
        input  O_busy
    );
endinterface

// File: rtl/uart_frame_rx64.sv
// Serial receiver: eight UART byte-frames (LSB first) reassembled into one 64-bit word.
// Even parity per byte is compiled in with `define UART_RX64_PARITY_EN.
module uart_frame_rx64 #(
    parameter int unsigned CLKS_PER_BIT = 10,
    parameter int unsigned TIMEOUT_BITS = 16
) (
    input logic               I_clk,
    input logic               I_rst,
    uart_frame_rx64_if.master bus_io
);

    localparam int unsigned CntW   = $clog2(CLKS_PER_BIT);
    localparam int unsigned TmoMax = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int unsigned TmoW   = $clog2(TmoMax + 1);

    // The cycle that detects the start edge counts toward the half-bit wait.
    localparam logic [CntW-1:0] HalfLoad = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] BitLoad  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [TmoW-1:0] TmoLast  = TmoW'(TmoMax - 1);
    localparam logic [TmoW-1:0] TmoSat   = TmoW'(TmoMax);

`ifdef UART_RX64_PARITY_EN
    localparam logic [3:0] LastSample = 4'd8;
`else
    localparam logic [3:0] LastSample = 4'd7;
`endif

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitHigh
    } state_e;

    logic            sync1_q;
    logic            rx_s_q;
    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [3:0]      nbit_q;
    logic [7:0]      shift_q;
    logic [2:0]      idx_q;
    logic [55:0]     word_q;
    logic [TmoW-1:0] tmo_q;
    logic [63:0]     data_q;
    logic            valid_q;
    logic            ferr_q;
    logic            tmo_p_q;
    logic            parity_ok;

`ifdef UART_RX64_PARITY_EN
    logic par_q;
    logic perr_q;

    assign parity_ok = ~^{shift_q, par_q};
    assign bus_io.O_parity_err = perr_q;
`else
    assign parity_ok = 1'b1;
    assign bus_io.O_parity_err = 1'b0;
`endif

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
            state_q <= StIdle;
            cnt_q   <= '0;
            nbit_q  <= 4'd0;
            shift_q <= 8'd0;
            idx_q   <= 3'd0;
            word_q  <= 56'd0;
            tmo_q   <= '0;
            data_q  <= 64'd0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            tmo_p_q <= 1'b0;
`ifdef UART_RX64_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            sync1_q <= bus_io.I_rxb;
            rx_s_q  <= sync1_q;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            tmo_p_q <= 1'b0;
`ifdef UART_RX64_PARITY_EN
            perr_q  <= 1'b0;
`endif
            unique case (state_q)
                StIdle: begin
                    if (idx_q != 3'd0 && tmo_q != TmoSat) begin
                        tmo_q <= tmo_q + 1'b1;
                        if (tmo_q == TmoLast) begin
                            tmo_p_q <= 1'b1;
                            idx_q   <= 3'd0;
                        end
                    end
                    // A start edge in the timeout cycle becomes byte 0 of a new word.
                    if (!rx_s_q) begin
                        state_q <= StStart;
                        cnt_q   <= HalfLoad;
                        tmo_q   <= '0;
                    end
                end

                StStart: begin
                    if (cnt_q == '0) begin
                        if (rx_s_q) begin
                            state_q <= StIdle;
                        end else begin
                            state_q <= StData;
                            cnt_q   <= BitLoad;
                            nbit_q  <= 4'd0;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end

                StData: begin
                    if (cnt_q == '0) begin
                        cnt_q <= BitLoad;
`ifdef UART_RX64_PARITY_EN
                        if (nbit_q[3]) begin
                            par_q <= rx_s_q;
                        end else begin
                            shift_q <= {rx_s_q, shift_q[7:1]};
                        end
`else
                        shift_q <= {rx_s_q, shift_q[7:1]};
`endif
                        if (nbit_q == LastSample) begin
                            state_q <= StStop;
                        end else begin
                            nbit_q <= nbit_q + 4'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end

                StStop: begin
                    if (cnt_q == '0) begin
                        if (!rx_s_q) begin
                            ferr_q  <= 1'b1;
                            idx_q   <= 3'd0;
                            state_q <= StWaitHigh;
                        end else if (!parity_ok) begin
`ifdef UART_RX64_PARITY_EN
                            perr_q  <= 1'b1;
`endif
                            idx_q   <= 3'd0;
                            state_q <= StIdle;
                        end else begin
                            // Bytes enter at the top so byte 0 ends up in the low lane.
                            if (idx_q == 3'd7) begin
                                data_q  <= {shift_q, word_q};
                                valid_q <= 1'b1;
                                idx_q   <= 3'd0;
                            end else begin
                                word_q <= {shift_q, word_q[55:8]};
                                idx_q  <= idx_q + 3'd1;
                            end
                            state_q <= StIdle;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end

                StWaitHigh: begin
                    if (rx_s_q) begin
                        state_q <= StIdle;
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus_io.O_data       = data_q;
    assign bus_io.O_data_valid = valid_q;
    assign bus_io.O_frame_err  = ferr_q;
    assign bus_io.O_timeout    = tmo_p_q;
    assign bus_io.O_busy       = (state_q != StIdle) || (idx_q != 3'd0);

endmodule

// File: tb/tb_uart_frame_rx64.sv
// Directed plus randomized bench for uart_frame_rx64; expectations come from the frame rules.
// Build with +define+UART_RX64_PARITY_EN to add the parity scenario.
module tb_uart_frame_rx64;

    localparam int C = 10;
    localparam int T = 16;
`ifdef UART_RX64_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    // Start edge on the line to the valid pulse: sync + half bit + remaining bits + output reg.
    localparam int LAT = 2 + C / 2 + (NBITS - 1) * C + 1;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    uart_frame_rx64_if bus ();

    uart_frame_rx64 #(
        .CLKS_PER_BIT(C),
        .TIMEOUT_BITS(T)
    ) dut (
        .I_clk (clk),
        .I_rst (rst),
        .bus_io(bus)
    );

    always #50 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    int          n_valid = 0, n_ferr = 0, n_perr = 0, n_tmo = 0;
    int          n_multi = 0, n_rst_bad = 0;
    logic [63:0] last_data = '0;
    int          last_valid_cyc = 0, last_tmo_cyc = 0;
    logic        busy_prev = 1'b0, busy_before_valid = 1'b0, busy_at_valid = 1'b0;
    logic        busy_at_tmo = 1'b0;
    int          t_start = 0, t_start7 = 0;
`ifdef UART_RX64_PARITY_EN
    logic        flip_par = 1'b0;
`endif

    always @(negedge clk) begin
        int np;
        np = int'(bus.O_data_valid) + int'(bus.O_frame_err) + int'(bus.O_parity_err)
             + int'(bus.O_timeout);
        if (np > 1) n_multi++;
        if (rst && (bus.O_data !== 64'd0 || np != 0 || bus.O_busy !== 1'b0)) n_rst_bad++;
        if (bus.O_data_valid === 1'b1) begin
            n_valid++;
            last_data         = bus.O_data;
            last_valid_cyc    = cyc;
            busy_at_valid     = bus.O_busy;
            busy_before_valid = busy_prev;
        end
        if (bus.O_frame_err === 1'b1) n_ferr++;
        if (bus.O_parity_err === 1'b1) n_perr++;
        if (bus.O_timeout === 1'b1) begin
            n_tmo++;
            last_tmo_cyc = cyc;
            busy_at_tmo  = bus.O_busy;
        end
        busy_prev = bus.O_busy;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int err_total();
        return n_ferr + n_perr + n_tmo;
    endfunction

    task automatic hold(input logic v, input int n);
        bus.I_rxb = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        t_start = cyc;
        hold(1'b0, C);
        for (int i = 0; i < 8; i++) hold(b[i], C);
`ifdef UART_RX64_PARITY_EN
        hold((^b) ^ flip_par, C);
`endif
        hold(stop_bit, C);
    endtask

    task automatic send_word(input logic [63:0] w);
        for (int k = 0; k < 8; k++) begin
            send_byte(w[8*k +: 8], 1'b1);
            if (k == 7) t_start7 = t_start;
        end
        hold(1'b1, 3 * C);
    endtask

    task automatic expect_word(input string tag, input logic [63:0] w, input int nv0,
                               input int ne0);
        chk({tag, "_count"}, 64'(n_valid - nv0), 64'd1);
        chk({tag, "_data"}, last_data, w);
        chk({tag, "_latency"}, 64'(last_valid_cyc - t_start7), 64'(LAT));
        chk({tag, "_busyfall"}, {62'd0, busy_before_valid, busy_at_valid}, 64'd2);
        chk({tag, "_noerr"}, 64'(err_total() - ne0), 64'd0);
    endtask

    initial begin
        int          nv0, ne0, nt0, nf0, np0, t2;
        logic [7:0]  rb [8];
        logic [63:0] exp_w;

        rst = 1'b0;
        bus.I_rxb = 1'b1;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", bus.O_data, 64'd0);
        chk("rst_valid", {63'd0, bus.O_data_valid}, 64'd0);
        chk("rst_ferr", {63'd0, bus.O_frame_err}, 64'd0);
        chk("rst_perr", {63'd0, bus.O_parity_err}, 64'd0);
        chk("rst_tmo", {63'd0, bus.O_timeout}, 64'd0);
        chk("rst_busy", {63'd0, bus.O_busy}, 64'd0);
        rst = 1'b0;
        hold(1'b1, 2 * C);

        // Nominal back-to-back word
        nv0 = n_valid; ne0 = err_total();
        send_word(64'h0123_4567_89AB_CDEF);
        expect_word("nominal", 64'h0123_4567_89AB_CDEF, nv0, ne0);

        // Short glitch on an idle line is ignored
        nv0 = n_valid; ne0 = err_total();
        hold(1'b0, 3);
        hold(1'b1, 2 * C);
        chk("glitch_busy", {63'd0, bus.O_busy}, 64'd0);
        send_word(64'hFFFF_0000_AAAA_5555);
        expect_word("glitch", 64'hFFFF_0000_AAAA_5555, nv0, ne0);

        // Framing error on byte 4 drops the word
        nv0 = n_valid; nf0 = n_ferr;
        for (int k = 0; k < 4; k++) send_byte(8'($urandom_range(255, 0)), 1'b1);
        send_byte(8'($urandom_range(255, 0)), 1'b0);
        hold(1'b0, 30);
        hold(1'b1, 2 * C);
        chk("ferr_count", 64'(n_ferr - nf0), 64'd1);
        chk("ferr_novalid", 64'(n_valid - nv0), 64'd0);
        chk("ferr_busy", {63'd0, bus.O_busy}, 64'd0);
        nv0 = n_valid; ne0 = err_total();
        send_word(64'h1);
        expect_word("after_ferr", 64'h1, nv0, ne0);

        // Inter-byte timeout after three bytes
        nv0 = n_valid; nt0 = n_tmo;
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        t2 = t_start;
        chk("tmo_busy_partial", {63'd0, bus.O_busy}, 64'd1);
        hold(1'b1, 20 * C);
        chk("tmo_count", 64'(n_tmo - nt0), 64'd1);
        chk("tmo_cycle", 64'(last_tmo_cyc - (t2 + LAT)), 64'(T * C));
        chk("tmo_busy", {63'd0, busy_at_tmo}, 64'd0);
        chk("tmo_novalid", 64'(n_valid - nv0), 64'd0);
        nv0 = n_valid; ne0 = err_total();
        send_word(64'hDEAD_BEEF_CAFE_F00D);
        expect_word("after_tmo", 64'hDEAD_BEEF_CAFE_F00D, nv0, ne0);

        // Reset in the middle of byte 5
        np0 = n_valid + err_total();
        for (int k = 0; k < 5; k++) send_byte(8'($urandom_range(255, 0)), 1'b1);
        hold(1'b0, C);
        hold(1'b1, C);
        hold(1'b0, C / 2);
        rst = 1'b1;
        bus.I_rxb = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_data", bus.O_data, 64'd0);
        chk("midrst_busy", {63'd0, bus.O_busy}, 64'd0);
        rst = 1'b0;
        hold(1'b1, 2 * C);
        chk("midrst_nopulse", 64'(n_valid + err_total() - np0), 64'd0);
        nv0 = n_valid; ne0 = err_total();
        send_word(64'h8000_0000_0000_0001);
        expect_word("after_rst", 64'h8000_0000_0000_0001, nv0, ne0);

`ifdef UART_RX64_PARITY_EN
        // Bad parity on byte 2 drops the word
        nv0 = n_valid; np0 = n_perr;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h5A, 1'b1);
        flip_par = 1'b1;
        send_byte(8'h3C, 1'b1);
        flip_par = 1'b0;
        hold(1'b1, 3 * C);
        chk("perr_count", 64'(n_perr - np0), 64'd1);
        chk("perr_novalid", 64'(n_valid - nv0), 64'd0);
        chk("perr_busy", {63'd0, bus.O_busy}, 64'd0);
        nv0 = n_valid; ne0 = err_total();
        send_word(64'h55);
        expect_word("after_perr", 64'h55, nv0, ne0);
`endif

        // Random words with random idle gaps shorter than the timeout
        for (int w = 0; w < 4; w++) begin
            nv0 = n_valid; ne0 = err_total();
            exp_w = 64'd0;
            for (int k = 0; k < 8; k++) begin
                rb[k] = 8'($urandom_range(255, 0));
                exp_w = exp_w + (64'(rb[k]) << (8 * k));
            end
            for (int k = 0; k < 8; k++) begin
                send_byte(rb[k], 1'b1);
                if (k == 7) t_start7 = t_start;
                else hold(1'b1, int'($urandom_range((T - 2) * C, 0)));
            end
            hold(1'b1, 3 * C);
            expect_word("random", exp_w, nv0, ne0);
        end

        chk("pulses_exclusive", 64'(n_multi), 64'd0);
        chk("reset_outputs_quiet", 64'(n_rst_bad), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_frame_rx64.md
# uart_frame_rx64

Serial receiver for the 64-bit inter-board word link: the receiving end of the framing produced by the UART word transmitter that drives the star-trigger differential lines. It samples one single-ended, already-IBUFDS'd line (`rxb[n]`) in the 10 MHz system domain. It reassembles eight byte-frames into one 64-bit word and presents it with a one-cycle valid strobe to the system-RAM loader or the ISA side. Framing errors, optional parity errors and inter-byte timeouts are flagged, and the partial word is discarded.

## Interface
- `CLKS_PER_BIT`, 10: clock cycles per serial bit; legal range 4..1023.
- `TIMEOUT_BITS`, 16: idle bit-times allowed between bytes of one word before the partial word is dropped; legal range 2..255.
- `I_clk`  in  1  system clock, 10 MHz (W1_Clk_10mhz).
- `I_rst`  in  1  asynchronous, active-high reset.
- `I_rxb`  in  1  serial line, idle high, asynchronous to `I_clk`.
- `O_data`  out  64  last complete word; byte 0 received = bits [7:0], byte 7 = bits [63:56].
- `O_data_valid`  out  1  one-cycle pulse; `O_data` is new.
- `O_frame_err`  out  1  one-cycle pulse; stop bit sampled low.
- `O_parity_err`  out  1  one-cycle pulse; parity mismatch (tied 0 when parity is compiled out).
- `O_timeout`  out  1  one-cycle pulse; partial word dropped on inter-byte timeout.
- `O_busy`  out  1  high from the first start bit of a word until that word completes or is dropped.

## Operation
- The input passes through a 2-flop synchronizer. All decisions use the synchronized value `rx_s`.
- Each byte is 1 start bit (0), 8 data bits LSB first, [parity], and 1 stop bit (1).
- The state machine has five states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - **IDLE:** `rx_s`=0 → START; the bit counter loads `CLKS_PER_BIT/2` (floor).
  - **START:** at mid-bit, `rx_s`=0 → DATA. `rx_s`=1 is a glitch → IDLE, with no flag and no change to the byte index.
  - **DATA:** samples every `CLKS_PER_BIT` cycles into a shift register. After 8 samples (plus the parity sample, if enabled) → STOP.
  - **STOP:** samples once, one bit-time after the last data or parity sample.
    - Stop=1 and parity OK: store the byte at the byte index, then increment the index. On byte 7: load `O_data`, pulse `O_data_valid`, index → 0. Then go to IDLE.
    - Stop=0: pulse `O_frame_err`, index → 0, partial word discarded → WAIT_HIGH.
    - Parity bad with stop=1: pulse `O_parity_err`, index → 0 → IDLE.
  - **WAIT_HIGH:** stays until `rx_s`=1, then → IDLE.
- Inter-byte timer:
  - Runs only in IDLE while the byte index ≠ 0, and is cleared on every START entry.
  - On reaching `TIMEOUT_BITS*CLKS_PER_BIT`: pulse `O_timeout`, index → 0, `O_busy` → 0.
  - If the timeout and a falling edge occur in the same cycle, the timeout wins. That start bit is then treated as byte 0 of a new word.
- `O_data` holds its value between words. It is never partially updated.
- `O_busy` = (state ≠ IDLE) or (index ≠ 0).

## Timing
- Reset values: `O_data`=0 and all pulses=0, `O_busy`=0, state IDLE, index 0, timer 0, synchronizer flops=1.
- Reset is honoured mid-frame: the partial word is lost, and no pulse is emitted during or on exit from reset.
- Latency from the falling edge of byte 7's start bit on `I_rxb` to `O_data_valid`: 2 + `CLKS_PER_BIT/2` + (9 [+1 parity])·`CLKS_PER_BIT` + 1 cycles. `O_data` is valid in the same cycle as the pulse.
- No backpressure exists. The consumer must accept a pulse every ≥ 80·`CLKS_PER_BIT` cycles, which is the minimum word spacing.
- At most one of `O_data_valid`, `O_frame_err`, `O_parity_err` and `O_timeout` is high in any cycle.
- Back-to-back bytes (stop bit directly followed by a start bit) must be received without loss. The STOP → IDLE transition happens at mid-stop-bit, so the next falling edge is always seen.
- Counters: the bit timer is `$clog2(CLKS_PER_BIT)` bits wide. The timeout counter is `$clog2(TIMEOUT_BITS*CLKS_PER_BIT+1)` bits wide and saturates, never wrapping.

## Configuration
- `UART_RX64_PARITY_EN`
  - Defined: an even-parity bit follows the 8 data bits of every byte. A mismatch is handled as described in Operation, and the frame is 11 bits.
  - Undefined: no parity bit, 10-bit frame, and `O_parity_err` is tied to 0. The parity logic is absent.

## Test plan
- **Nominal word:** `CLKS_PER_BIT`=10; send 64'h0123_4567_89AB_CDEF as bytes EF, CD, AB, 89, 67, 45, 23, 01 back-to-back → exactly one `O_data_valid` with `O_data`=64'h0123456789ABCDEF, at the computed latency. `O_busy` falls in the same cycle.
- **Glitch:** a 3-cycle low pulse on an idle line, then a full word 64'hFFFF_0000_AAAA_5555 → no flags, one valid with that value.
- **Framing error:** byte 4 sent with stop=0, line held low 30 cycles, then a full word 64'h1 → one `O_frame_err`, no valid for the broken word, then valid with `O_data`=64'h1.
- **Timeout:** 3 bytes, then 20 idle bit-times, then word 64'hDEAD_BEEF_CAFE_F00D → `O_timeout` exactly 160 cycles after entering IDLE following byte 2, then one valid with 64'hDEADBEEFCAFEF00D.
- **Reset mid-word:** assert `I_rst` during byte 5 for 3 cycles, then send word 64'h8000_0000_0000_0001 → all outputs 0 during reset, no stray pulse, then one valid with 64'h8000000000000001.
- **Parity** (with `UART_RX64_PARITY_EN`): corrupt the parity of byte 2 → one `O_parity_err`, and the word is dropped. The next clean word 64'h55 is received correctly.
